keccak_job_sequencer: RTL and testbench

- Sequences one hash job at a time through the exported Keccak IP's three valid/ready streams (PARMS, DATA, RESULTS).
- Accepts a job descriptor (hash size and message length), issues the PARMS word, and streams exactly ceil(len/8) message words from the source into the IP.
- Collects hash_bits/64 digest words and forwards them downstream with a last marker.
- Sits between host-side FIFOs and the IP; owns IP reset and timeout recovery.

---
 rtl/keccak_seq_pkg.sv | 23 ++
 rtl/keccak_seq_timeout.sv | 28 ++
 rtl/keccak_job_sequencer.sv | 178 +++++++++++++++++
 tb/tb_keccak_job_sequencer.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keccak_seq_pkg.sv
// Shared types and constants for the Keccak job sequencer.
// Holds the FSM state encoding, the legal digest sizes and the PARMS word layout.
package keccak_seq_pkg;

  typedef enum logic [2:0] {
    RECOVER,
    IDLE,
    PARMS,
    DATA,
    COLLECT
  } state_t;

  localparam logic [31:0] HASH_256 = 32'd256;
  localparam logic [31:0] HASH_512 = 32'd512;

  localparam int PARMS_HASH_LSB = 32;
  localparam int PARMS_LEN_LSB  = 0;

  function automatic logic hash_legal(input logic [31:0] hash_bits);
    return (hash_bits == HASH_256) || (hash_bits == HASH_512);
  endfunction

endpackage

// File: rtl/keccak_seq_timeout.sv
// Idle-cycle counter for the result stream.
// Counts enabled cycles since the last clear; expired flags the cycle that reaches LIMIT.
module keccak_seq_timeout #(
  parameter int LIMIT = 4096
) (
  input  logic clk,
  input  logic srst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (srst || clear) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  // The cycle being counted now is the LIMIT-th one without progress.
  assign expired = enable && !clear && (count_reg == W'(LIMIT - 1));

endmodule

// File: rtl/keccak_job_sequencer.sv
// Runs one hash job at a time through the Keccak IP PARMS/DATA/RESULTS streams.
// Owns the IP reset, including recovery after a result timeout.
module keccak_job_sequencer
  import keccak_seq_pkg::*;
#(
  parameter int RESULT_TIMEOUT = 4096,
  parameter int IP_RST_CYCLES  = 4,
  parameter int CNT_W          = 30
) (
  input  logic        Clk40,
  input  logic        reset,
  input  logic        job_valid,
  output logic        job_ready,
  input  logic [31:0] job_hash_bits,
  input  logic [31:0] job_len_bytes,
  input  logic        src_valid,
  input  logic [63:0] src_data,
  output logic        src_ready,
  output logic        ip_reset,
  output logic        ip_parms_valid,
  output logic [63:0] ip_parms_element,
  input  logic        ip_parms_ready,
  output logic        ip_data_valid,
  output logic [63:0] ip_data_element,
  input  logic        ip_data_ready,
  input  logic        ip_results_valid,
  input  logic [63:0] ip_results_element,
  output logic        ip_results_ready,
  output logic        dig_valid,
  output logic [63:0] dig_data,
  output logic        dig_last,
  input  logic        dig_ready,
  output logic        busy,
  output logic        err_badjob,
  output logic        err_timeout
);

  state_t           state_reg, state_next;
  logic [31:0]      hash_reg, hash_next;
  logic [31:0]      len_reg, len_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             err_badjob_reg, err_badjob_next;
  logic             err_timeout_reg, err_timeout_next;

  logic [32:0]      len_round;
  logic [CNT_W-1:0] job_nwords;
  logic [CNT_W-1:0] nres;
  logic             in_data, in_collect;
  logic             data_xfer, res_xfer, tmo_expired;

  // 33-bit sum so a length near 2^32 still rounds up correctly.
  assign len_round  = {1'b0, job_len_bytes} + 33'd7;
  assign job_nwords = CNT_W'(len_round >> 3);
  assign nres       = CNT_W'(hash_reg >> 6);

  assign in_data    = !reset && (state_reg == DATA);
  assign in_collect = !reset && (state_reg == COLLECT);
  assign data_xfer  = in_data && src_valid && ip_data_ready;
  assign res_xfer   = in_collect && ip_results_valid && dig_ready;

  keccak_seq_timeout #(
    .LIMIT(RESULT_TIMEOUT)
  ) u_timeout (
    .clk    (Clk40),
    .srst   (reset),
    .clear  (!in_collect || res_xfer),
    .enable (in_collect && !res_xfer),
    .expired(tmo_expired)
  );

  always_ff @(posedge Clk40) begin
    if (reset) begin
      state_reg       <= RECOVER;
      hash_reg        <= '0;
      len_reg         <= '0;
      cnt_reg         <= CNT_W'(IP_RST_CYCLES);
      err_badjob_reg  <= 1'b0;
      err_timeout_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      hash_reg        <= hash_next;
      len_reg         <= len_next;
      cnt_reg         <= cnt_next;
      err_badjob_reg  <= err_badjob_next;
      err_timeout_reg <= err_timeout_next;
    end
  end

  // cnt_reg is shared: recovery countdown, then words to send, then digest words left.
  always_comb begin
    state_next       = state_reg;
    hash_next        = hash_reg;
    len_next         = len_reg;
    cnt_next         = cnt_reg;
    err_badjob_next  = 1'b0;
    err_timeout_next = 1'b0;
    case (state_reg)
      RECOVER: begin
        if (cnt_reg <= CNT_W'(1)) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      IDLE: begin
        if (job_valid) begin
          if (hash_legal(job_hash_bits)) begin
            hash_next  = job_hash_bits;
            len_next   = job_len_bytes;
            cnt_next   = job_nwords;
            state_next = PARMS;
          end else begin
            err_badjob_next = 1'b1;
          end
        end
      end
      PARMS: begin
        if (ip_parms_ready) begin
          if (cnt_reg != '0) begin
            state_next = DATA;
          end else begin
            cnt_next   = nres;
            state_next = COLLECT;
          end
        end
      end
      DATA: begin
        if (data_xfer) begin
          if (cnt_reg == CNT_W'(1)) begin
            cnt_next   = nres;
            state_next = COLLECT;
          end else begin
            cnt_next = cnt_reg - 1'b1;
          end
        end
      end
      COLLECT: begin
        if (res_xfer) begin
          if (cnt_reg == CNT_W'(1)) begin
            state_next = IDLE;
          end else begin
            cnt_next = cnt_reg - 1'b1;
          end
        end else if (tmo_expired) begin
          cnt_next         = CNT_W'(IP_RST_CYCLES);
          err_timeout_next = 1'b1;
          state_next       = RECOVER;
        end
      end
      default: begin
        cnt_next   = CNT_W'(IP_RST_CYCLES);
        state_next = RECOVER;
      end
    endcase
  end

  always_comb begin
    ip_parms_element = '0;
    ip_reset         = reset || (state_reg == RECOVER);
    job_ready        = !reset && (state_reg == IDLE);
    ip_parms_valid   = !reset && (state_reg == PARMS);
    if (ip_parms_valid) begin
      ip_parms_element[PARMS_HASH_LSB +: 32] = hash_reg;
      ip_parms_element[PARMS_LEN_LSB +: 32]  = len_reg;
    end
    ip_data_valid    = in_data && src_valid;
    src_ready        = in_data && ip_data_ready;
    ip_data_element  = in_data ? src_data : '0;
    dig_valid        = in_collect && ip_results_valid;
    ip_results_ready = in_collect && dig_ready;
    dig_data         = in_collect ? ip_results_element : '0;
    dig_last         = in_collect && (cnt_reg == CNT_W'(1));
    busy             = !reset && (state_reg != IDLE);
    err_badjob       = !reset && err_badjob_reg;
    err_timeout      = !reset && err_timeout_reg;
  end

endmodule

// File: tb/tb_keccak_job_sequencer.sv
// Randomized bench for keccak_job_sequencer against a queue-based job model.
// The bench plays host source, Keccak IP and digest sink; one negedge process checks every cycle.
module tb_keccak_job_sequencer;

  localparam int RT  = 4096;
  localparam int IRC = 4;

  logic        Clk40 = 1'b0;
  logic        reset = 1'b1;
  logic        job_valid = 1'b0;
  logic [31:0] job_hash_bits = '0;
  logic [31:0] job_len_bytes = '0;
  logic        src_valid = 1'b0;
  logic [63:0] src_data = '0;
  logic        ip_parms_ready = 1'b0;
  logic        ip_data_ready = 1'b0;
  logic        ip_results_valid = 1'b0;
  logic [63:0] ip_results_element = '0;
  logic        dig_ready = 1'b0;

  logic        job_ready, src_ready, ip_reset, ip_parms_valid, ip_data_valid;
  logic        ip_results_ready, dig_valid, dig_last, busy, err_badjob, err_timeout;
  logic [63:0] ip_parms_element, ip_data_element, dig_data;

  always #5 Clk40 = ~Clk40;

  keccak_job_sequencer #(
    .RESULT_TIMEOUT(RT),
    .IP_RST_CYCLES (IRC),
    .CNT_W         (30)
  ) dut (
    .Clk40             (Clk40),
    .reset             (reset),
    .job_valid         (job_valid),
    .job_ready         (job_ready),
    .job_hash_bits     (job_hash_bits),
    .job_len_bytes     (job_len_bytes),
    .src_valid         (src_valid),
    .src_data          (src_data),
    .src_ready         (src_ready),
    .ip_reset          (ip_reset),
    .ip_parms_valid    (ip_parms_valid),
    .ip_parms_element  (ip_parms_element),
    .ip_parms_ready    (ip_parms_ready),
    .ip_data_valid     (ip_data_valid),
    .ip_data_element   (ip_data_element),
    .ip_data_ready     (ip_data_ready),
    .ip_results_valid  (ip_results_valid),
    .ip_results_element(ip_results_element),
    .ip_results_ready  (ip_results_ready),
    .dig_valid         (dig_valid),
    .dig_data          (dig_data),
    .dig_last          (dig_last),
    .dig_ready         (dig_ready),
    .busy              (busy),
    .err_badjob        (err_badjob),
    .err_timeout       (err_timeout)
  );

  logic [63:0] src_q[$], exp_data_q[$], res_q[$], exp_dig_q[$], fixed_q[$];
  logic [63:0] exp_parms, cap_parms, first_data, prev_de, prev_dd;
  bit          parms_pending, rand_stall, no_results, job_done;
  bit          dx_f, rx_f, data_stall_prev, dig_stall_prev;
  int          nwords_m, nres_m, dcnt, rcnt, last_cnt, last_idx;
  int          nbad, ntmo, cyc, last_data_cyc, tmo_cyc;
  int          tests, fails;

  task automatic note_fail(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    fails++;
    $display("FAIL %s: actual=%0h required=%0h", name, act, req);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    if (act !== req) begin
      note_fail(name, act, req);
    end else begin
      tests++;
    end
  endtask

  // The IP produces its digest only once PARMS and every message word have arrived.
  task automatic release_results();
    logic [63:0] w;
    if (!no_results) begin
      for (int i = 0; i < nres_m; i++) begin
        w = {$urandom, $urandom};
        res_q.push_back(w);
        exp_dig_q.push_back(w);
      end
    end
  endtask

  // Compare process: outputs sampled mid-cycle equal what the next rising edge sees.
  initial begin
    logic [63:0] w;
    cyc = 0;
    forever begin
      @(negedge Clk40);
      cyc++;
      dx_f = ip_data_valid && ip_data_ready;
      rx_f = dig_valid && dig_ready;
      if (reset) begin
        chk("reset_ip_reset", {63'd0, ip_reset}, 64'd1);
        chk("reset_ctl_zero", {54'd0, job_ready, src_ready, ip_parms_valid, ip_data_valid,
                               ip_results_ready, dig_valid, dig_last, busy, err_badjob,
                               err_timeout}, 64'd0);
        chk("reset_data_zero", ip_parms_element | ip_data_element | dig_data, 64'd0);
        data_stall_prev = 1'b0;
        dig_stall_prev  = 1'b0;
      end else begin
        if (ip_parms_valid) chk("parms_without_job", {63'd0, ip_parms_valid}, {63'd0, parms_pending});
        if (src_ready) chk("src_ready_no_words", 64'd1, (exp_data_q.size() > 0) ? 64'd1 : 64'd0);
        if (ip_parms_valid && ip_parms_ready) begin
          chk("parms_element", ip_parms_element, exp_parms);
          cap_parms     = ip_parms_element;
          parms_pending = 1'b0;
          if (nwords_m == 0) release_results();
        end
        if (data_stall_prev) begin
          chk("data_valid_held", {63'd0, ip_data_valid}, 64'd1);
          chk("data_stable", ip_data_element, prev_de);
        end
        if (dx_f) begin
          chk("src_ready_on_data", {63'd0, src_ready}, 64'd1);
          if (exp_data_q.size() == 0) begin
            note_fail("data_extra", ip_data_element, 64'd0);
          end else begin
            w = exp_data_q.pop_front();
            chk("data_word", ip_data_element, w);
          end
          if (dcnt == 0) first_data = ip_data_element;
          dcnt++;
          last_data_cyc = cyc;
          if (dcnt == nwords_m) release_results();
        end
        if (dig_stall_prev) begin
          chk("dig_valid_held", {63'd0, dig_valid}, 64'd1);
          chk("dig_stable", dig_data, prev_dd);
        end
        if (rx_f) begin
          chk("results_ready", {63'd0, ip_results_ready}, 64'd1);
          if (exp_dig_q.size() == 0) begin
            note_fail("dig_extra", dig_data, 64'd0);
          end else begin
            w = exp_dig_q.pop_front();
            chk("dig_data", dig_data, w);
            chk("dig_last", {63'd0, dig_last}, (exp_dig_q.size() == 0) ? 64'd1 : 64'd0);
          end
          rcnt++;
          if (dig_last) begin
            last_cnt++;
            last_idx = rcnt;
          end
          if (exp_dig_q.size() == 0) job_done = 1'b1;
        end
        if (err_badjob) nbad++;
        if (err_timeout) begin
          ntmo++;
          tmo_cyc = cyc;
        end
        data_stall_prev = ip_data_valid && !ip_data_ready;
        prev_de         = ip_data_element;
        dig_stall_prev  = dig_valid && !dig_ready;
        prev_dd         = dig_data;
      end
    end
  end

  // Source, IP and sink drivers, updated just after each rising edge.
  initial begin
    forever begin
      @(posedge Clk40);
      #1;
      if (dx_f && src_q.size() > 0) void'(src_q.pop_front());
      if (rx_f && res_q.size() > 0) void'(res_q.pop_front());
      src_valid      = src_q.size() > 0;
      src_data       = (src_q.size() > 0) ? src_q[0] : 64'd0;
      ip_parms_ready = rand_stall ? ($urandom_range(1, 0) == 1) : 1'b1;
      ip_data_ready  = rand_stall ? ($urandom_range(1, 0) == 1) : 1'b1;
      dig_ready      = rand_stall ? ($urandom_range(1, 0) == 1) : 1'b1;
      if (reset) begin
        ip_results_valid = 1'b0;
      end else if (!(ip_results_valid && !rx_f)) begin
        ip_results_valid = (res_q.size() > 0) && (!rand_stall || ($urandom_range(1, 0) == 1));
      end
      ip_results_element = (res_q.size() > 0) ? res_q[0] : 64'd0;
    end
  end

  task automatic cycle_wait();
    @(posedge Clk40);
    #2;
  endtask

  task automatic do_reset(input int n);
    reset         = 1'b1;
    job_valid     = 1'b0;
    parms_pending = 1'b0;
    src_q.delete();
    exp_data_q.delete();
    res_q.delete();
    exp_dig_q.delete();
    repeat (n) cycle_wait();
    reset = 1'b0;
  endtask

  task automatic measure_recover(input string name);
    int n;
    n = 0;
    while (ip_reset && n < 64) begin
      n++;
      cycle_wait();
    end
    chk(name, 64'(n), 64'(IRC));
    chk({name, "_idle"}, {63'd0, job_ready}, 64'd1);
  endtask

  task automatic start_job(input logic [31:0] hb, input logic [31:0] len, input bit nores);
    logic [63:0] w;
    bit          accepted;
    dcnt = 0; rcnt = 0; last_cnt = 0; last_idx = 0;
    no_results = nores;
    job_done   = 1'b0;
    if (hb == 32'd256 || hb == 32'd512) begin
      nwords_m = int'((longint'(len) + 7) / 8);
      nres_m   = int'(hb) / 64;
      for (int i = 0; i < nwords_m; i++) begin
        w = (fixed_q.size() > 0) ? fixed_q.pop_front() : {$urandom, $urandom};
        src_q.push_back(w);
        exp_data_q.push_back(w);
      end
      exp_parms     = {hb, len};
      parms_pending = 1'b1;
    end else begin
      nwords_m = 0;
      nres_m   = 0;
    end
    job_valid     = 1'b1;
    job_hash_bits = hb;
    job_len_bytes = len;
    accepted      = 1'b0;
    for (int n = 0; n < 100 && !accepted; n++) begin
      accepted = job_ready;
      cycle_wait();
    end
    if (!accepted) note_fail("job_accept_timeout", 64'd0, 64'd1);
    job_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!job_done && n < budget) begin
      cycle_wait();
      n++;
    end
    if (!job_done) begin
      note_fail("job_done_timeout", 64'(n), 64'(budget));
    end else begin
      chk("busy_after_job", {63'd0, busy}, 64'd0);
      chk("job_ready_after_job", {63'd0, job_ready}, 64'd1);
      chk("dig_count", 64'(rcnt), 64'(nres_m));
      chk("data_count", 64'(dcnt), 64'(nwords_m));
      chk("last_count", 64'(last_cnt), 64'd1);
    end
  endtask

  initial begin
    int b0, t0, n;
    tests = 0; fails = 0; nbad = 0; ntmo = 0;
    rand_stall = 1'b0;
    repeat (3) cycle_wait();
    reset = 1'b0;
    measure_recover("recover_after_reset");

    fixed_q = '{64'h6168747345207341, 64'h6465727269747320};
    start_job(32'd256, 32'd16, 1'b0);
    wait_done(200);
    chk("j256_parms", cap_parms, 64'h0000010000000010);
    chk("j256_first_word", first_data, 64'h6168747345207341);
    chk("j256_data_count", 64'(dcnt), 64'd2);
    chk("j256_last_idx", 64'(last_idx), 64'd4);

    start_job(32'd512, 32'd0, 1'b0);
    wait_done(200);
    chk("j512_parms", cap_parms, 64'h0000020000000000);
    chk("j512_data_count", 64'(dcnt), 64'd0);
    chk("j512_last_idx", 64'(last_idx), 64'd8);

    b0 = nbad;
    start_job(32'd300, 32'd16, 1'b0);
    chk("bad_pulse", {63'd0, err_badjob}, 64'd1);
    chk("bad_job_ready", {63'd0, job_ready}, 64'd1);
    cycle_wait();
    chk("bad_pulse_gone", {63'd0, err_badjob}, 64'd0);
    repeat (3) cycle_wait();
    chk("bad_pulse_count", 64'(nbad - b0), 64'd1);
    chk("bad_not_busy", {63'd0, busy}, 64'd0);

    rand_stall = 1'b1;
    start_job(32'd256, 32'd9, 1'b0);
    wait_done(500);
    chk("len9_data_count", 64'(dcnt), 64'd2);
    chk("len9_dig_count", 64'(rcnt), 64'd4);
    for (int j = 0; j < 12; j++) begin
      start_job(($urandom_range(1, 0) == 1) ? 32'd512 : 32'd256, 32'($urandom_range(64, 0)), 1'b0);
      wait_done(1000);
    end
    rand_stall = 1'b0;

    t0 = ntmo;
    start_job(32'd256, 32'd8, 1'b1);
    n = 0;
    while (!err_timeout && n < RT + 100) begin
      cycle_wait();
      n++;
    end
    chk("tmo_seen", {63'd0, err_timeout}, 64'd1);
    measure_recover("recover_after_timeout");
    chk("tmo_delay", 64'(tmo_cyc - last_data_cyc), 64'(RT + 1));
    chk("tmo_pulse_count", 64'(ntmo - t0), 64'd1);

    start_job(32'd256, 32'd24, 1'b0);
    n = 0;
    while (dcnt < 1 && n < 50) begin
      cycle_wait();
      n++;
    end
    do_reset(2);
    chk("mid_reset_dcount", 64'(dcnt), 64'd1);
    measure_recover("recover_after_mid_reset");
    start_job(32'd256, 32'd8, 1'b0);
    wait_done(200);
    chk("post_reset_parms", cap_parms, 64'h0000010000000008);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5ms;
    note_fail("global_watchdog", 64'd0, 64'd1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog expired");
  end

endmodule
